// File: rtl/backdoor_spi_shift_ctrl_pkg.sv
// Shared types and constants for the backdoor SPI shift-chain sequencer.
package backdoor_spi_shift_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_CAPTURE,
    ST_WAIT_CS
  } state_t;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_N_IDLE = 1'b1;

  // Bit counter must hold 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/backdoor_sync_ff.sv
// Multi-flop single-bit synchronizer with a configurable synchronous reset level.
module backdoor_sync_ff
  import backdoor_spi_shift_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = SCLK_IDLE
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_D,
  output logic o_Q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_D};
    end
  end

  assign o_Q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/backdoor_spi_shift_ctrl.sv
// Sequences a backdoor_spi_dff_buffer from an SPI slave port and hands each
// completed frame word to the register logic over valid/ready.
module backdoor_spi_shift_ctrl
  import backdoor_spi_shift_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_SCLK,
  input  logic                  i_CS_N,
  input  logic                  i_MOSI,
  output logic                  o_BUF_RST,
  output logic                  o_SHIFT_EN,
  output logic                  o_SHIFT_D,
  input  logic [DATA_WIDTH-1:0] i_BUF_Q,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_VALID,
  input  logic                  i_READY,
  output logic                  o_ABORT,
  output logic                  o_OVERRUN,
  output logic                  o_BUSY
);

  localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s;
  logic cs_n_s;
  logic mosi_s;
  logic sclk_hist;
  logic cs_n_hist;
  logic sclk_rise;
  logic cs_n_fall;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;

  backdoor_sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_D(i_SCLK), .o_Q(sclk_s)
  );

  backdoor_sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CS_N_IDLE)) u_sync_cs_n (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_D(i_CS_N), .o_Q(cs_n_s)
  );

  backdoor_sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_D(i_MOSI), .o_Q(mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_hist;
  assign cs_n_fall = ~cs_n_s & cs_n_hist;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sclk_hist  <= SCLK_IDLE;
      cs_n_hist  <= CS_N_IDLE;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      o_BUF_RST  <= 1'b1;
      o_SHIFT_EN <= 1'b0;
      o_SHIFT_D  <= 1'b0;
      o_DATA     <= '0;
      o_VALID    <= 1'b0;
      o_ABORT    <= 1'b0;
      o_OVERRUN  <= 1'b0;
      o_BUSY     <= 1'b0;
    end else begin
      sclk_hist  <= sclk_s;
      cs_n_hist  <= cs_n_s;
      o_BUF_RST  <= 1'b0;
      o_SHIFT_EN <= 1'b0;
      o_ABORT    <= 1'b0;
      if (o_VALID && i_READY) begin
        o_VALID <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cs_n_fall) begin
            state     <= ST_CLEAR;
            o_BUF_RST <= 1'b1;
            o_BUSY    <= 1'b1;
          end
        end

        ST_CLEAR: begin
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end

        // A final edge coinciding with CS_N rise still completes the frame.
        ST_SHIFT: begin
          if (bit_cnt == CNT_FULL) begin
            state <= ST_CAPTURE;
          end else if (sclk_rise && (!cs_n_s || bit_cnt == CNT_LAST)) begin
            o_SHIFT_EN <= 1'b1;
            o_SHIFT_D  <= mosi_s;
            bit_cnt    <= bit_cnt + CNT_W'(1);
          end else if (cs_n_s) begin
            o_ABORT <= 1'b1;
            o_BUSY  <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        // Consuming and capturing in the same cycle keeps o_VALID asserted.
        ST_CAPTURE: begin
          if (!o_VALID || i_READY) begin
            o_DATA  <= i_BUF_Q;
            o_VALID <= 1'b1;
          end else begin
            o_OVERRUN <= 1'b1;
          end
          state <= ST_WAIT_CS;
        end

        ST_WAIT_CS: begin
          if (cs_n_s) begin
            o_BUSY <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: begin
          o_BUSY <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_backdoor_spi_shift_ctrl.sv
// Self-checking bench: SPI master stimulus, shift-chain buffer model, frame-level reference.
module tb_backdoor_spi_shift_ctrl;

  localparam int unsigned W    = 8;
  localparam int          HALF = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         buf_rst;
  logic         shift_en;
  logic         shift_d;
  logic [W-1:0] buf_q = '0;
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         abort;
  logic         overrun;
  logic         busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int shift_pulses = 0;
  int abort_pulses = 0;
  int valid_cycles = 0;

  logic [W-1:0] exp_data;
  logic         exp_valid;
  logic         exp_ovr;

  always #5 clk = ~clk;

  backdoor_spi_shift_ctrl #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_CLK(clk), .i_RST(rst), .i_SCLK(sclk), .i_CS_N(cs_n), .i_MOSI(mosi),
    .o_BUF_RST(buf_rst), .o_SHIFT_EN(shift_en), .o_SHIFT_D(shift_d),
    .i_BUF_Q(buf_q), .o_DATA(data), .o_VALID(valid), .i_READY(ready),
    .o_ABORT(abort), .o_OVERRUN(overrun), .o_BUSY(busy)
  );

  // Shift-chain buffer: synchronous clear, MSB-first shift on enable.
  always_ff @(posedge clk) begin
    if (buf_rst) buf_q <= '0;
    else if (shift_en) buf_q <= {buf_q[W-2:0], shift_d};
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_pulses <= shift_pulses + 1;
    if (abort) abort_pulses <= abort_pulses + 1;
    if (valid) valid_cycles <= valid_cycles + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    else pass_cnt++;
  endtask

  task automatic spi_bits(input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[nbits-1-i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [15:0] bits, input int nbits);
    cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(bits, nbits);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; ready = 1'b0;
    wait_clk(3);
    chk("reset_buf_rst", 32'(buf_rst), 32'd1);
    chk("reset_shift_en", 32'(shift_en), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_flags", {29'd0, abort, overrun, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(3);
    chk("idle_buf_rst", 32'(buf_rst), 32'd0);
  endtask

  task automatic test_normal_frame();
    int s0, a0, v0;
    ready = 1'b1;
    s0 = shift_pulses; a0 = abort_pulses; v0 = valid_cycles;
    spi_frame(16'h00A5, 8);
    chk("normal_shifts", 32'(shift_pulses - s0), 32'd8);
    chk("normal_data", 32'(data), 32'hA5);
    chk("normal_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    chk("normal_abort", 32'(abort_pulses - a0), 32'd0);
    chk("normal_overrun", 32'(overrun), 32'd0);
    chk("normal_idle", {30'd0, valid, busy}, 32'd0);
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    spi_frame(16'h003C, 8);
    chk("bp_first_data", 32'(data), 32'h3C);
    chk("bp_first_valid", 32'(valid), 32'd1);
    chk("bp_first_ovr", 32'(overrun), 32'd0);
    spi_frame(16'h00C3, 8);
    chk("bp_kept_data", 32'(data), 32'h3C);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_still_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    wait_clk(1);
    chk("bp_valid_drop", 32'(valid), 32'd0);
    chk("bp_ovr_sticky", 32'(overrun), 32'd1);
  endtask

  task automatic test_abort();
    int a0;
    do_reset();
    ready = 1'b1;
    a0 = abort_pulses;
    cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(16'h0005, 3);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(10);
    chk("abort_pulses", 32'(abort_pulses - a0), 32'd1);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    spi_frame(16'h0081, 8);
    chk("abort_next_data", 32'(data), 32'h81);
  endtask

  task automatic test_extra_bits();
    int s0;
    s0 = shift_pulses;
    spi_frame(16'h03C3, 10);
    chk("extra_shifts", 32'(shift_pulses - s0), 32'd8);
    chk("extra_data", 32'(data), 32'hF0);
  endtask

  task automatic test_reset_mid_frame();
    cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(16'h0015, 5);
    rst = 1'b1;
    wait_clk(1);
    chk("midrst_buf_rst", 32'(buf_rst), 32'd1);
    chk("midrst_outs", {26'd0, shift_en, valid, abort, overrun, busy, 1'b0}, 32'd0);
    chk("midrst_data", 32'(data), 32'd0);
    cs_n = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    spi_frame(16'h005A, 8);
    chk("midrst_next_data", 32'(data), 32'h5A);
  endtask

  task automatic test_collision();
    bit seen;
    ready = 1'b0;
    spi_frame(16'h0011, 8);
    chk("coll_hold", {23'd0, valid, data}, {23'd0, 1'b1, 8'h11});
    cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(16'h0011, 7);
    mosi = 1'b0;
    wait_clk(HALF);
    sclk = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (shift_en) seen = 1'b1;
    end
    total_cnt++;
    if (!seen) $display("FAIL coll_timeout: got no shift pulse, expected one within 20 cycles");
    else pass_cnt++;
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    chk("coll_data", 32'(data), 32'h22);
    chk("coll_valid", 32'(valid), 32'd1);
    chk("coll_ovr", 32'(overrun), 32'd0);
    wait_clk(HALF);
    sclk = 1'b0;
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic test_random();
    logic [W-1:0] word;
    bit           rdy;
    do_reset();
    exp_data = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
    for (int n = 0; n < 20; n++) begin
      word = W'($urandom);
      rdy = 1'($urandom_range(0, 1));
      ready = rdy;
      spi_frame({8'd0, word}, 8);
      if (rdy) begin
        exp_data = word; exp_valid = 1'b0;
      end else if (!exp_valid) begin
        exp_data = word; exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
      chk("rand_data", 32'(data), 32'(exp_data));
      chk("rand_valid", 32'(valid), 32'(exp_valid));
      chk("rand_ovr", 32'(overrun), 32'(exp_ovr));
    end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_backpressure();
    test_abort();
    test_extra_bits();
    test_reset_mid_frame();
    test_collision();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/backdoor_spi_shift_ctrl.md
Name: backdoor_spi_shift_ctrl

Overview:
Sequencer that drives a backdoor_spi_dff_buffer shift chain from an external SPI slave interface. It synchronizes SCLK/CS_N/MOSI into the i_CLK domain and issues one single-cycle shift enable per SCLK rising edge. It counts bits per frame, clears the buffer at frame start, and captures the parallel buffer word when a frame completes. The captured word is presented on a valid/ready handshake to the backdoor register logic.

Parameters:
DATA_WIDTH, 8, bits per frame; must equal the BUFFER_WIDTH of the attached buffer; must be >= 2.
SYNC_STAGES, 2, flops per input synchronizer; must be >= 2.

Ports:
i_CLK  in  1  system clock; all logic on rising edge.
i_RST  in  1  reset; synchronous, active-high.
i_SCLK  in  1  SPI clock, asynchronous; mode 0, sampled on rising edge.
i_CS_N  in  1  SPI chip select, asynchronous, active-low.
i_MOSI  in  1  SPI serial data, asynchronous, MSB first.
o_BUF_RST  out  1  to buffer i_RST; clears the buffer at frame start.
o_SHIFT_EN  out  1  to buffer i_EN; one-cycle pulse per accepted bit.
o_SHIFT_D  out  1  to buffer i_D; bit to shift in.
i_BUF_Q  in  DATA_WIDTH  parallel buffer contents.
o_DATA  out  DATA_WIDTH  captured frame word.
o_VALID  out  1  o_DATA holds an unconsumed word.
i_READY  in  1  consumer accepts o_DATA when o_VALID & i_READY.
o_ABORT  out  1  one-cycle pulse when CS_N rises mid-frame.
o_OVERRUN  out  1  sticky: a frame completed while o_VALID was still pending.
o_BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_RST=1 at a clock edge): state=IDLE, bit counter=0, synchronizer flops and edge history=idle levels (SCLK=0, CS_N=1), o_BUF_RST=1, o_SHIFT_EN=0, o_SHIFT_D=0, o_DATA=0, o_VALID=0, o_ABORT=0, o_OVERRUN=0, o_BUSY=0. Reset overrides every other event, including a frame in progress; the partial frame is discarded with no valid and no abort.
- Synchronization: each SPI input passes through SYNC_STAGES flops. Edges are detected against one additional history flop. The detection latency from pin to internal event is SYNC_STAGES+1 cycles.
- Timing constraint: SCLK high and low phases must each be >= SYNC_STAGES+2 i_CLK cycles. Faster SCLK is out of scope and its behaviour is unspecified.
- FSM states: IDLE, CLEAR, SHIFT, CAPTURE, WAIT_CS.
  - IDLE: o_BUF_RST=0. On a synchronized CS_N falling edge, go to CLEAR.
  - CLEAR (1 cycle): o_BUF_RST=1, counter=0; go to SHIFT.
  - SHIFT: on a synchronized SCLK rising edge with CS_N low, drive o_SHIFT_EN=1 for exactly one cycle with o_SHIFT_D equal to synchronized MOSI, and increment the counter. When the counter reaches DATA_WIDTH, go to CAPTURE on the next cycle.
  - SHIFT abort: if CS_N rises with counter < DATA_WIDTH, pulse o_ABORT for 1 cycle, return to IDLE, and leave o_VALID/o_DATA untouched.
  - CAPTURE (1 cycle): the buffer has absorbed the last bit by now.
    - If o_VALID=0, or o_VALID=1 with i_READY=1 in the same cycle, set o_DATA<=i_BUF_Q and o_VALID<=1.
    - Otherwise set o_OVERRUN<=1, drop the new word, and keep the old o_DATA.
    - Then go to WAIT_CS.
  - WAIT_CS: ignore extra SCLK edges (no shift enable). On CS_N rise, go to IDLE with no abort.
  - Simultaneous CS_N rise and final SCLK edge: the edge is processed first (frame completes). The CS rise is then handled in WAIT_CS.
- Handshake: o_VALID clears on the cycle after o_VALID & i_READY, unless CAPTURE sets it again in that same cycle. o_DATA is stable while o_VALID=1.
- o_OVERRUN clears only on reset.
- Counter width: clog2(DATA_WIDTH+1) bits; it never wraps because it saturates by leaving SHIFT.

Decomposition:
- Shared package: FSM state enum, the counter-width function (clog2), and the idle-level constants for SCLK and CS_N.
- One natural sub-module: backdoor_sync_ff, a SYNC_STAGES-deep single-bit synchronizer with synchronous reset value. Instantiate it three times.
- Top-level testbench instantiates the controller together with a real backdoor_spi_dff_buffer.

Test Plan:
- Normal frame: DATA_WIDTH=8, send 0xA5 MSB first, i_READY=1 -> exactly 8 o_SHIFT_EN pulses; o_DATA=0xA5, o_VALID high for 1 cycle; o_ABORT=0; o_OVERRUN=0.
- Back-pressure: send 0x3C with i_READY=0, then 0xC3 -> o_DATA stays 0x3C, o_OVERRUN=1. Raising i_READY drops o_VALID next cycle.
- Abort: CS_N low, 3 SCLK edges, CS_N high -> one o_ABORT pulse, o_VALID=0, state IDLE. The next full frame 0x81 yields o_DATA=0x81 (buffer cleared by CLEAR).
- Extra bits: 10 SCLK edges in one CS window sending 0xF0 followed by 2'b11 -> 8 shift pulses only, o_DATA=0xF0.
- Reset mid-frame: assert i_RST after 5 bits -> all outputs at reset values on the next edge. The following frame 0x5A is captured correctly.
- Consume-and-capture collision: o_VALID=1 holding 0x11, and i_READY=1 in the same cycle as CAPTURE of 0x22 -> o_DATA=0x22, o_VALID stays 1, o_OVERRUN=0.
